// File: rtl/pipelined_alu.sv
// Pipelined, handshaked ALU with registered result and flags.
//
// Single-cycle ops (add, sub, not, and, or, shifts, branches, slt) register
// their result on the accept edge. Signed multiply spends WIDTH cycles in the
// MUL state before its result is registered.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand handshake (a, b, op)
//   a, b            signed operands; b[SHW-1:0] is the shift amount
//   op              4-bit operation select
//   out_valid/ready result handshake
//   f               registered result
//   ovf             registered signed-overflow flag
//   zero            registered f == 0 flag
//   take_branch     registered branch decision
//   busy            high while a multiply is in flight
module pipelined_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             ovf,
  output logic             zero,
  output logic             take_branch,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpNot = 4'b0010;
  localparam logic [3:0] OpAnd = 4'b0011;
  localparam logic [3:0] OpOr  = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpSll = 4'b0110;
  localparam logic [3:0] OpSrl = 4'b0111;
  localparam logic [3:0] OpBeq = 4'b1000;
  localparam logic [3:0] OpBne = 4'b1001;
  localparam logic [3:0] OpSlt = 4'b1010;
  localparam logic [3:0] OpMul = 4'b1011;

  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             ovf_q, ovf_d, zero_q, zero_d, tb_q, tb_d;

  logic               accept;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_ovf, alu_tb;
  logic [2*WIDTH-1:0] prod;
  logic               mul_ovf;

  assign in_ready  = (state_q == StIdle) | ((state_q == StHold) & out_ready);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q == StMul);
  assign accept    = in_valid & in_ready;

  assign f           = f_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;
  assign take_branch = tb_q;

  assign shamt = b[SHW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the
  // signed product, so an unsigned multiply suffices.
  assign prod    = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign mul_ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});

  // Single-cycle datapath on the live inputs.
  always_comb begin
    alu_f   = '0;
    alu_ovf = 1'b0;
    alu_tb  = 1'b0;
    case (op)
      OpAdd: begin
        alu_f   = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_f   = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpNot: alu_f = ~b;
      OpAnd: alu_f = a & b;
      OpOr:  alu_f = a | b;
      OpSra: alu_f = $unsigned($signed(a) >>> shamt);
      OpSll: alu_f = a << shamt;
      OpSrl: alu_f = a >> shamt;
      OpBeq: alu_tb = (a == b);
      OpBne: alu_tb = (a != b);
      OpSlt: alu_f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        alu_f   = '0;
        alu_ovf = 1'b0;
        alu_tb  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    tb_d    = tb_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          if (op == OpMul) begin
            state_d = StMul;
            cnt_d   = SHW'(WIDTH - 1);
            a_d     = a;
            b_d     = b;
          end else begin
            state_d = StHold;
            f_d     = alu_f;
            ovf_d   = alu_ovf;
            zero_d  = (alu_f == '0);
            tb_d    = alu_tb;
          end
        end else if ((state_q == StHold) && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          f_d     = prod[WIDTH-1:0];
          ovf_d   = mul_ovf;
          zero_d  = (prod[WIDTH-1:0] == '0);
          tb_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      tb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      tb_q    <= tb_d;
    end
  end

endmodule
